multicycle_ctrl: RTL and testbench

- Moore-style sequencing FSM that drives a shared-memory, multicycle version of the MIPS-subset datapath.
- Replaces the single-cycle control unit when instruction fetch and data access share one memory port.
- Each instruction is broken into fetch/decode/execute/memory/writeback steps.
- Waits on a memory ready handshake and flags unsupported opcodes.

---
 rtl/multicycle_ctrl_if.sv | 40 ++++
 rtl/multicycle_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multicycle sequencer and its datapath.
// slave = controller side, master = datapath (or bench) side.
interface multicycle_ctrl_if #(
    parameter int OP_W = 6,
    parameter int FN_W = 6,
    parameter int ST_W = 4
);
    logic [OP_W-1:0] opcode;
    logic [FN_W-1:0] funct;
    logic            zero;
    logic            mem_ready;
    logic            mem_read;
    logic            mem_write;
    logic            iord;
    logic            ir_write;
    logic            pc_write;
    logic [1:0]      pc_src;
    logic            alu_src_a;
    logic [1:0]      alu_src_b;
    logic [2:0]      alu_ctrl;
    logic [1:0]      reg_dst;
    logic [1:0]      mem_to_reg;
    logic            reg_write;
    logic            illegal_op;
    logic [ST_W-1:0] state;

    modport slave (
        input  opcode, funct, zero, mem_ready,
        output mem_read, mem_write, iord, ir_write, pc_write, pc_src,
               alu_src_a, alu_src_b, alu_ctrl, reg_dst, mem_to_reg,
               reg_write, illegal_op, state
    );

    modport master (
        output opcode, funct, zero, mem_ready,
        input  mem_read, mem_write, iord, ir_write, pc_write, pc_src,
               alu_src_a, alu_src_b, alu_ctrl, reg_dst, mem_to_reg,
               reg_write, illegal_op, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore sequencer for the shared-memory multicycle MIPS-subset datapath.
// Define MULTICYCLE_CTRL_JALJR_EN to enable the jal and jr sequences.
module multicycle_ctrl #(
    parameter int OP_W = 6,
    parameter int FN_W = 6,
    parameter int ST_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    multicycle_ctrl_if.slave bus
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_REX    = 4'd6,  S_RWB   = 4'd7,
        S_BEQ    = 4'd8,  S_IEX    = 4'd9,  S_IWB    = 4'd10, S_JMP   = 4'd11,
        S_JAL    = 4'd12, S_JR     = 4'd13, S_TRAP   = 4'd14
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
    localparam logic [OP_W-1:0] OP_JAL   = OP_W'(6'b000011);
    localparam logic [FN_W-1:0] FN_JR    = FN_W'(6'b001000);

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t     state_q, state_d;
    logic       jal_hold_q, jal_hold_d;
    logic       illegal_q, illegal_d;
    logic       mem_read_q, mem_read_d, mem_write_q, mem_write_d;
    logic       iord_q, iord_d, pc_write_q, pc_write_d;
    logic       alu_src_a_q, alu_src_a_d, reg_write_q, reg_write_d;
    logic [1:0] pc_src_q, pc_src_d, alu_src_b_q, alu_src_b_d;
    logic [1:0] reg_dst_q, reg_dst_d, mem_to_reg_q, mem_to_reg_d;
    logic [2:0] alu_ctrl_q, alu_ctrl_d;
    logic [2:0] rex_alu;
    logic       funct_ok;

    always_comb begin
        funct_ok = 1'b1;
        rex_alu  = 3'b000;
        case (bus.funct)
            FN_W'(6'b100000): rex_alu = ALU_ADD;
            FN_W'(6'b100010): rex_alu = ALU_SUB;
            FN_W'(6'b100100): rex_alu = ALU_AND;
            FN_W'(6'b100101): rex_alu = ALU_OR;
            FN_W'(6'b101010): rex_alu = ALU_SLT;
            default:          funct_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        jal_hold_d = 1'b0;
        case (state_q)
            S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE: begin
                        if (bus.funct == FN_JR) begin
`ifdef MULTICYCLE_CTRL_JALJR_EN
                            state_d = S_JR;
`else
                            state_d = S_TRAP;
`endif
                        end else begin
                            state_d = S_REX;
                        end
                    end
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_ADDI:      state_d = S_IEX;
                    OP_J:         state_d = S_JMP;
                    OP_JAL: begin
`ifdef MULTICYCLE_CTRL_JALJR_EN
                        state_d = S_JAL;
`else
                        state_d = S_TRAP;
`endif
                    end
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR: state_d = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (bus.mem_ready) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (bus.mem_ready) state_d = S_FETCH;
            S_REX:    state_d = funct_ok ? S_RWB : S_TRAP;
            S_RWB, S_BEQ, S_IWB, S_JMP, S_JR: state_d = S_FETCH;
            S_IEX:    state_d = S_IWB;
            // First JAL cycle idles the ALU; the write happens in the second.
            S_JAL: begin
                if (!jal_hold_q) begin
                    state_d    = S_JAL;
                    jal_hold_d = 1'b1;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_TRAP;
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet
    // line up with the state they belong to.
    always_comb begin
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        iord_d       = 1'b0;
        pc_write_d   = 1'b0;
        pc_src_d     = 2'b00;
        alu_src_a_d  = 1'b0;
        alu_src_b_d  = 2'b00;
        alu_ctrl_d   = 3'b000;
        reg_dst_d    = 2'b00;
        mem_to_reg_d = 2'b00;
        reg_write_d  = 1'b0;
        case (state_d)
            S_FETCH:  begin mem_read_d = 1'b1; alu_src_b_d = 2'b01; alu_ctrl_d = ALU_ADD; end
            S_DECODE: begin alu_src_b_d = 2'b11; alu_ctrl_d = ALU_ADD; end
            S_MEMADR: begin alu_src_a_d = 1'b1; alu_src_b_d = 2'b10; alu_ctrl_d = ALU_ADD; end
            S_MEMRD:  begin mem_read_d = 1'b1; iord_d = 1'b1; end
            S_MEMWB:  begin reg_write_d = 1'b1; mem_to_reg_d = 2'b01; end
            S_MEMWR:  begin mem_write_d = 1'b1; iord_d = 1'b1; end
            S_REX:    begin alu_src_a_d = 1'b1; alu_ctrl_d = rex_alu; end
            S_RWB:    begin reg_write_d = 1'b1; reg_dst_d = 2'b01; end
            S_BEQ:    begin alu_src_a_d = 1'b1; alu_ctrl_d = ALU_SUB; pc_src_d = 2'b01; end
            S_IEX:    begin alu_src_a_d = 1'b1; alu_src_b_d = 2'b10; alu_ctrl_d = ALU_ADD; end
            S_IWB:    begin reg_write_d = 1'b1; end
            S_JMP:    begin pc_write_d = 1'b1; pc_src_d = 2'b10; end
            S_JAL: begin
                reg_dst_d    = 2'b10;
                mem_to_reg_d = 2'b10;
                pc_src_d     = 2'b10;
                reg_write_d  = jal_hold_d;
                pc_write_d   = jal_hold_d;
            end
            S_JR:     begin pc_write_d = 1'b1; pc_src_d = 2'b11; end
            default:  ;
        endcase
    end

    assign illegal_d = illegal_q | (state_d == S_TRAP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_FETCH;
            jal_hold_q   <= 1'b0;
            illegal_q    <= 1'b0;
            mem_read_q   <= 1'b1;
            mem_write_q  <= 1'b0;
            iord_q       <= 1'b0;
            pc_write_q   <= 1'b0;
            pc_src_q     <= 2'b00;
            alu_src_a_q  <= 1'b0;
            alu_src_b_q  <= 2'b01;
            alu_ctrl_q   <= ALU_ADD;
            reg_dst_q    <= 2'b00;
            mem_to_reg_q <= 2'b00;
            reg_write_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            jal_hold_q   <= jal_hold_d;
            illegal_q    <= illegal_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            iord_q       <= iord_d;
            pc_write_q   <= pc_write_d;
            pc_src_q     <= pc_src_d;
            alu_src_a_q  <= alu_src_a_d;
            alu_src_b_q  <= alu_src_b_d;
            alu_ctrl_q   <= alu_ctrl_d;
            reg_dst_q    <= reg_dst_d;
            mem_to_reg_q <= mem_to_reg_d;
            reg_write_q  <= reg_write_d;
        end
    end

    // FETCH loads IR/PC and BEQ loads PC in the cycle the input arrives,
    // so those terms are combinational; rst masks every strobe immediately.
    assign bus.mem_read   = mem_read_q & ~rst;
    assign bus.mem_write  = mem_write_q & ~rst;
    assign bus.reg_write  = reg_write_q & ~rst;
    assign bus.ir_write   = (state_q == S_FETCH) & bus.mem_ready & ~rst;
    assign bus.pc_write   = (pc_write_q
                             | ((state_q == S_FETCH) & bus.mem_ready)
                             | ((state_q == S_BEQ) & bus.zero)) & ~rst;
    assign bus.iord       = iord_q;
    assign bus.pc_src     = pc_src_q;
    assign bus.alu_src_a  = alu_src_a_q;
    assign bus.alu_src_b  = alu_src_b_q;
    assign bus.alu_ctrl   = alu_ctrl_q;
    assign bus.reg_dst    = reg_dst_q;
    assign bus.mem_to_reg = mem_to_reg_q;
    assign bus.illegal_op = illegal_q;
    assign bus.state      = ST_W'(state_q);
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class and
// compares every control output against hand-derived vectors.
module tb_multicycle_ctrl;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    multicycle_ctrl_if #(.OP_W(6), .FN_W(6), .ST_W(4)) bus ();

    multicycle_ctrl #(.OP_W(6), .FN_W(6), .ST_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Field order: state, mem_read, mem_write, iord, ir_write, pc_write,
    // pc_src, alu_src_a, alu_src_b, alu_ctrl, reg_dst, mem_to_reg,
    // reg_write, illegal_op.
    task automatic chk(input string tag, input int st, input int mr, input int mw,
                       input int io, input int irw, input int pcw, input int pcs,
                       input int a, input int b, input int alu, input int rd,
                       input int m2r, input int rw, input int ill);
        logic [22:0] obs;
        logic [22:0] exp;
        obs = {bus.state, bus.mem_read, bus.mem_write, bus.iord, bus.ir_write,
               bus.pc_write, bus.pc_src, bus.alu_src_a, bus.alu_src_b,
               bus.alu_ctrl, bus.reg_dst, bus.mem_to_reg, bus.reg_write,
               bus.illegal_op};
        exp = {4'(st), 1'(mr), 1'(mw), 1'(io), 1'(irw), 1'(pcw), 2'(pcs),
               1'(a), 2'(b), 3'(alu), 2'(rd), 2'(m2r), 1'(rw), 1'(ill)};
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%06h expected=%06h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.mem_ready = 1'b1;
        bus.opcode = 6'b100011;
        bus.funct = 6'b000000;
        bus.zero = 1'b0;
        #3;
        chk("reset_hold",       0, 0,0,0,0,0, 0, 0,1,2, 0,0,0, 0);
        tick();
        tick();
        chk("reset_edges",      0, 0,0,0,0,0, 0, 0,1,2, 0,0,0, 0);
        rst = 1'b0;
        #1;
        chk("reset_release",    0, 1,0,0,1,1, 0, 0,1,2, 0,0,0, 0);

        // lw, memory always ready
        tick(); chk("lw_decode",    1, 0,0,0,0,0, 0, 0,3,2, 0,0,0, 0);
        tick(); chk("lw_memadr",    2, 0,0,0,0,0, 0, 1,2,2, 0,0,0, 0);
        tick(); chk("lw_memrd",     3, 1,0,1,0,0, 0, 0,0,0, 0,0,0, 0);
        tick(); chk("lw_memwb",     4, 0,0,0,0,0, 0, 0,0,0, 0,1,1, 0);
        tick(); chk("lw_fetch",     0, 1,0,0,1,1, 0, 0,1,2, 0,0,0, 0);

        // sw with three wait cycles in MEMWR
        bus.opcode = 6'b101011;
        tick(); chk("sw_decode",    1, 0,0,0,0,0, 0, 0,3,2, 0,0,0, 0);
        tick(); chk("sw_memadr",    2, 0,0,0,0,0, 0, 1,2,2, 0,0,0, 0);
        bus.mem_ready = 1'b0;
        tick(); chk("sw_wait1",     5, 0,1,1,0,0, 0, 0,0,0, 0,0,0, 0);
        tick(); chk("sw_wait2",     5, 0,1,1,0,0, 0, 0,0,0, 0,0,0, 0);
        tick(); chk("sw_wait3",     5, 0,1,1,0,0, 0, 0,0,0, 0,0,0, 0);
        bus.mem_ready = 1'b1;
        #1;     chk("sw_done",      5, 0,1,1,0,0, 0, 0,0,0, 0,0,0, 0);
        tick(); chk("sw_fetch",     0, 1,0,0,1,1, 0, 0,1,2, 0,0,0, 0);

        // fetch stall
        bus.mem_ready = 1'b0;
        #1;     chk("fetch_wait",   0, 1,0,0,0,0, 0, 0,1,2, 0,0,0, 0);
        tick(); chk("fetch_wait2",  0, 1,0,0,0,0, 0, 0,1,2, 0,0,0, 0);

        // beq taken; mem_ready low in DECODE must not stall
        bus.opcode = 6'b000100;
        bus.zero = 1'b1;
        bus.mem_ready = 1'b1;
        tick(); chk("beq_decode",   1, 0,0,0,0,0, 0, 0,3,2, 0,0,0, 0);
        bus.mem_ready = 1'b0;
        tick(); chk("beq_taken",    8, 0,0,0,0,1, 1, 1,0,6, 0,0,0, 0);
        bus.zero = 1'b0;
        #1;     chk("beq_zero_drop",8, 0,0,0,0,0, 1, 1,0,6, 0,0,0, 0);
        bus.mem_ready = 1'b1;
        tick(); chk("beq_fetch",    0, 1,0,0,1,1, 0, 0,1,2, 0,0,0, 0);

        // beq not taken
        tick();
        tick(); chk("beq_not_taken",8, 0,0,0,0,0, 1, 1,0,6, 0,0,0, 0);
        tick(); chk("beq_nt_fetch", 0, 1,0,0,1,1, 0, 0,1,2, 0,0,0, 0);

        // R-type slt
        bus.opcode = 6'b000000;
        bus.funct = 6'b101010;
        tick();
        tick(); chk("slt_rex",      6, 0,0,0,0,0, 0, 1,0,7, 0,0,0, 0);
        tick(); chk("slt_rwb",      7, 0,0,0,0,0, 0, 0,0,0, 1,0,1, 0);
        tick();

        // addi
        bus.opcode = 6'b001000;
        tick();
        tick(); chk("addi_iex",     9, 0,0,0,0,0, 0, 1,2,2, 0,0,0, 0);
        tick(); chk("addi_iwb",    10, 0,0,0,0,0, 0, 0,0,0, 0,0,1, 0);
        tick();

        // j
        bus.opcode = 6'b000010;
        tick();
        tick(); chk("j_jmp",       11, 0,0,0,0,1, 2, 0,0,0, 0,0,0, 0);
        tick(); chk("j_fetch",      0, 1,0,0,1,1, 0, 0,1,2, 0,0,0, 0);

        // reset in the middle of an R-type add
        bus.opcode = 6'b000000;
        bus.funct = 6'b100000;
        tick();
        tick(); chk("add_rex",      6, 0,0,0,0,0, 0, 1,0,2, 0,0,0, 0);
        #2;
        rst = 1'b1;
        #1;     chk("rst_mid_rex",  0, 0,0,0,0,0, 0, 0,1,2, 0,0,0, 0);
        tick(); chk("rst_mid_hold", 0, 0,0,0,0,0, 0, 0,1,2, 0,0,0, 0);
        rst = 1'b0;
        #1;     chk("rst_mid_rel",  0, 1,0,0,1,1, 0, 0,1,2, 0,0,0, 0);

        // unsupported funct traps and stays trapped
        bus.funct = 6'b000111;
        tick();
        tick(); chk("bad_fn_rex",   6, 0,0,0,0,0, 0, 1,0,0, 0,0,0, 0);
        tick(); chk("bad_fn_trap", 14, 0,0,0,0,0, 0, 0,0,0, 0,0,0, 1);
        for (int i = 0; i < 10; i++) tick();
        chk("trap_sticky",         14, 0,0,0,0,0, 0, 0,0,0, 0,0,0, 1);

        // jal
        rst = 1'b1;
        #1;     chk("trap_cleared", 0, 0,0,0,0,0, 0, 0,1,2, 0,0,0, 0);
        tick();
        rst = 1'b0;
        bus.opcode = 6'b000011;
        tick(); chk("jal_decode",   1, 0,0,0,0,0, 0, 0,3,2, 0,0,0, 0);
        tick();
`ifdef MULTICYCLE_CTRL_JALJR_EN
        chk("jal_idle",            12, 0,0,0,0,0, 2, 0,0,0, 2,2,0, 0);
        tick(); chk("jal_write",   12, 0,0,0,0,1, 2, 0,0,0, 2,2,1, 0);
        tick(); chk("jal_fetch",    0, 1,0,0,1,1, 0, 0,1,2, 0,0,0, 0);
`else
        chk("jal_trap",            14, 0,0,0,0,0, 0, 0,0,0, 0,0,0, 1);
`endif

        // jr
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.opcode = 6'b000000;
        bus.funct = 6'b001000;
        tick();
        tick();
`ifdef MULTICYCLE_CTRL_JALJR_EN
        chk("jr_exec",             13, 0,0,0,0,1, 3, 0,0,0, 0,0,0, 0);
        tick(); chk("jr_fetch",     0, 1,0,0,1,1, 0, 0,1,2, 0,0,0, 0);
`else
        chk("jr_trap",             14, 0,0,0,0,0, 0, 0,0,0, 0,0,0, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
